// File: rtl/eth_axis_pkg.sv
// Shared types and helpers for the UDP payload to AXI-Stream packer.
package eth_axis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } packer_state_t;

  // Widest keep mask the helper can build; callers truncate to their width.
  localparam int KEEP_MAX = 64;

  // Mask of width w with the top n bits set (lane 0 lives in the MSB).
  function automatic logic [KEEP_MAX-1:0] keep_from_count(input int n, input int w);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if ((i < w) && (i >= w - n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A write while full is only accepted when a read happens in the same cycle.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LVL_W'(DEPTH));
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Accept/reject decisions and next pointer/count values.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_wr && !do_rd) count_d = count_q + LVL_W'(1);
    else if (!do_wr && do_rd) count_d = count_q - LVL_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/udp_axis_packer.sv
// Packs a level-valid UDP payload byte stream into OUT_BYTES-wide AXI-Stream
// words with tkeep/tlast, buffered by a FWFT FIFO that absorbs backpressure.
// AXIS handshake: a word transfers on a cycle where tvalid and tready are both
// high; tvalid never depends on tready and the word is held while stalled.
module udp_axis_packer
  import eth_axis_pkg::*;
#(
  parameter int OUT_BYTES  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [7:0]             data_in,
  input  logic                   udp_data_valid,
  output logic [OUT_BYTES*8-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   overflow,
  output logic                   overflow_sticky,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int W     = OUT_BYTES * 8;
  localparam int IDX_W = $clog2(OUT_BYTES);
  localparam int ENT_W = 1 + OUT_BYTES + W;

  packer_state_t      state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic               overflow_q, overflow_d;
  logic               sticky_q, sticky_d;

  logic               push;
  logic [W-1:0]       push_data;
  logic [OUT_BYTES-1:0] push_keep;
  logic               push_last;
  logic [W-1:0]       acc_wr;
  logic [W-1:0]       acc_first;
  logic               last_lane;

  logic [ENT_W-1:0]   fifo_rd_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               drop;

  // Accumulator with the incoming byte placed at lane idx, and a fresh
  // accumulator holding only the incoming byte at lane 0.
  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < OUT_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) acc_wr[W-1-8*k -: 8] = data_in;
    end
    acc_first          = '0;
    acc_first[W-1 -: 8] = data_in;
    last_lane          = (idx_q == IDX_W'(OUT_BYTES - 1));
  end

  // Packer FSM: next state, datapath updates and the single FIFO push.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    push      = 1'b0;
    push_data = hold_q;
    push_keep = '1;
    push_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (udp_data_valid) begin
          acc_d   = acc_first;
          idx_d   = IDX_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (udp_data_valid) begin
          if (hold_v_q) begin
            push     = 1'b1;
            hold_v_d = 1'b0;
          end
          if (last_lane) begin
            hold_d   = acc_wr;
            hold_v_d = 1'b1;
            acc_d    = '0;
            idx_d    = '0;
          end else begin
            acc_d = acc_wr;
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          // Frame end: the held word is the last one only if acc is empty.
          if (hold_v_q) begin
            push     = 1'b1;
            hold_v_d = 1'b0;
            if (idx_q == '0) begin
              push_last = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end else begin
            if (idx_q != '0) begin
              push      = 1'b1;
              push_data = acc_q;
              push_keep = OUT_BYTES'(keep_from_count(int'(idx_q), OUT_BYTES));
              push_last = 1'b1;
            end
            acc_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        push      = 1'b1;
        push_data = acc_q;
        push_keep = OUT_BYTES'(keep_from_count(int'(idx_q), OUT_BYTES));
        push_last = 1'b1;
        if (udp_data_valid) begin
          acc_d   = acc_first;
          idx_d   = IDX_W'(1);
          state_d = COLLECT;
        end else begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d    = '0;
        idx_d    = '0;
        hold_v_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Drop detection: a push into a full FIFO survives only with a same-cycle pop.
  always_comb begin
    pop        = !fifo_empty && m_axis_tready;
    drop       = push && fifo_full && !pop;
    overflow_d = drop;
    sticky_d   = sticky_q || drop;
  end

  // Packer state and status registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      overflow_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      overflow_q <= overflow_d;
      sticky_q   <= sticky_d;
    end
  end

  axis_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .wr_en   (push),
    .wr_data ({push_last, push_keep, push_data}),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  // Output word is forced to zero while nothing is queued.
  assign m_axis_tvalid = !fifo_empty;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_empty ? '0 : fifo_rd_data;
  assign overflow        = overflow_q;
  assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_udp_axis_packer.sv
// Bench for udp_axis_packer with OUT_BYTES=4 and a 4-entry FIFO.
module tb_udp_axis_packer;

  localparam int OB = 4;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          areset;
  logic [7:0]    data_in;
  logic          udp_data_valid;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          overflow;
  logic          overflow_sticky;
  logic [LW-1:0] fifo_level;

  always #5 aclk = ~aclk;

  udp_axis_packer #(
    .OUT_BYTES  (OB),
    .FIFO_DEPTH (FD)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .data_in         (data_in),
    .udp_data_valid  (udp_data_valid),
    .m_axis_tdata    (tdata),
    .m_axis_tkeep    (tkeep),
    .m_axis_tlast    (tlast),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky),
    .fifo_level      (fifo_level)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] exp_q[$];
  bit          mon_en   = 1'b0;
  int          ov_cnt   = 0;
  bit          prev_stall = 1'b0;
  logic [37:0] prev_word;
  logic [7:0]  fbuf[64];

  typedef struct packed {
    logic [7:0]       len;
    logic [7:0]       b0;
    logic [7:0]       step;
    logic             chk_idle;
    logic [1:0]       nw;
    logic [2:0][36:0] w;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: matches every transferred word against exp_q, checks
  // stall stability, level bound, and counts overflow pulses.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (prev_stall) check("stall_hold", {26'd0, tvalid, tlast, tkeep, tdata}, {26'd0, prev_word});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {tlast, tkeep, tdata});
        end else begin
          check("word", {27'd0, tlast, tkeep, tdata}, {27'd0, exp_q.pop_front()});
        end
      end
      if (overflow) ov_cnt++;
      check("level_bound", 64'(fifo_level > LW'(FD)), 64'd0);
      prev_stall = tvalid && !tready;
      prev_word  = {tvalid, tlast, tkeep, tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_frame(input int len, input bit tog);
    for (int i = 0; i < len; i++) begin
      data_in        = fbuf[i];
      udp_data_valid = 1'b1;
      if (tog) tready = ~tready;
      tick();
    end
    udp_data_valid = 1'b0;
    data_in        = 8'h00;
  endtask

  // Reference packing: byte k of a word lands in the MSB-first lane k.
  task automatic model_expect(input int len);
    for (int base = 0; base < len; base += OB) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = '0;
      k = '0;
      for (int j = 0; j < OB; j++) begin
        if (base + j < len) begin
          d[31-8*j -: 8] = fbuf[base+j];
          k[3-j]         = 1'b1;
        end
      end
      exp_q.push_back({(base + OB >= len), k, d});
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !tvalid) break;
      tick();
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(tvalid), 64'd0);
  endtask

  task automatic set_vec(input int i, input logic [7:0] len, input logic [7:0] b0,
                         input logic [7:0] step, input logic chk, input logic [1:0] nw,
                         input logic [36:0] w0, input logic [36:0] w1);
    vecs[i].len      = len;
    vecs[i].b0       = b0;
    vecs[i].step     = step;
    vecs[i].chk_idle = chk;
    vecs[i].nw       = nw;
    vecs[i].w[0]     = w0;
    vecs[i].w[1]     = w1;
    vecs[i].w[2]     = '0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    set_vec(0, 8'd8, 8'h01, 8'h01, 1'b1, 2'd2, {1'b0, 4'hF, 32'h01020304}, {1'b1, 4'hF, 32'h05060708});
    set_vec(1, 8'd5, 8'hAA, 8'h11, 1'b0, 2'd2, {1'b0, 4'hF, 32'hAABBCCDD}, {1'b1, 4'h8, 32'hEE000000});
    set_vec(2, 8'd1, 8'h5A, 8'h00, 1'b1, 2'd1, {1'b1, 4'h8, 32'h5A000000}, '0);
    set_vec(3, 8'd2, 8'h11, 8'h11, 1'b1, 2'd1, {1'b1, 4'hC, 32'h11220000}, '0);
    set_vec(4, 8'd3, 8'h10, 8'h10, 1'b1, 2'd1, {1'b1, 4'hE, 32'h10203000}, '0);
    set_vec(5, 8'd4, 8'hC0, 8'h01, 1'b1, 2'd1, {1'b1, 4'hF, 32'hC0C1C2C3}, '0);

    areset         = 1'b1;
    data_in        = 8'h00;
    udp_data_valid = 1'b0;
    tready         = 1'b1;
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_word", {27'd0, tlast, tkeep, tdata}, 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", {62'd0, overflow, overflow_sticky}, 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Table-driven frames, back to back with a single low cycle between them.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) fbuf[i] = 8'(int'(vecs[v].b0) + i * int'(vecs[v].step));
      for (int n = 0; n < int'(vecs[v].nw); n++) exp_q.push_back(vecs[v].w[n]);
      drive_frame(int'(vecs[v].len), 1'b0);
      if (vecs[v].chk_idle) check($sformatf("lat_pre_v%0d", v), 64'(tvalid), 64'd0);
      tick();
      check($sformatf("lat_last_v%0d", v), {62'd0, tvalid, tlast}, 64'd3);
    end
    wait_drain("vectors");

    // 40-byte frame with tready toggling every cycle.
    for (int i = 0; i < 40; i++) fbuf[i] = 8'(i * 7 + 3);
    model_expect(40);
    tready = 1'b0;
    drive_frame(40, 1'b1);
    tready = 1'b1;
    tick();
    wait_drain("toggle");

    // Six single-word frames into a stalled 4-entry FIFO.
    ov_cnt = 0;
    tready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 4; j++) fbuf[j] = 8'((f + 1) * 16 + j);
      if (f < 4) model_expect(4);
      drive_frame(4, 1'b0);
      tick();
    end
    tick();
    tick();
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_pulses", 64'(ov_cnt), 64'd2);
    check("ovf_sticky", 64'(overflow_sticky), 64'd1);
    check("ovf_head", {27'd0, tlast, tkeep, tdata}, {27'd0, 1'b1, 4'hF, 32'h10111213});
    tready = 1'b1;
    wait_drain("overflow");
    check("ovf_level_after", 64'(fifo_level), 64'd0);
    check("ovf_sticky_kept", 64'(overflow_sticky), 64'd1);

    // Reset mid-frame with two words queued.
    tready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) fbuf[j] = 8'(8'hA0 + f * 16 + j);
      drive_frame(4, 1'b0);
      tick();
    end
    check("pre_rst_level", 64'(fifo_level), 64'd2);
    for (int j = 0; j < 3; j++) begin
      data_in        = 8'(8'hC0 + j);
      udp_data_valid = 1'b1;
      tick();
    end
    mon_en = 1'b0;
    areset = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_word", {27'd0, tlast, tkeep, tdata}, 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_ovf", {62'd0, overflow, overflow_sticky}, 64'd0);
    udp_data_valid = 1'b0;
    data_in        = 8'h00;
    tick();
    areset = 1'b0;
    exp_q.delete();
    tready = 1'b1;
    tick();
    mon_en = 1'b1;
    for (int j = 0; j < 4; j++) fbuf[j] = 8'(j + 1);
    exp_q.push_back({1'b1, 4'hF, 32'h01020304});
    drive_frame(4, 1'b0);
    tick();
    check("post_rst_word", {27'd0, tlast, tkeep, tdata}, {27'd0, 1'b1, 4'hF, 32'h01020304});
    wait_drain("post_reset");
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
